// File: rtl/elm_neuron_mac_par_pkg.sv
// Shared definitions for the parallel-MAC ELM hidden neuron: defaults,
// activation encodings, FSM states and the saturate/activate function.
package elm_neuron_mac_par_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int FRAC_W_DEF   = 8;
   localparam int ACT_IDENTITY = 0;
   localparam int ACT_RELU     = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_BIAS,
      S_ACT,
      S_HOLD
   } state_t;

   // Clamp to a data_w-bit signed range, then optionally zero negatives.
   function automatic logic signed [63:0] sat_act(input logic signed [63:0] x,
                                                  input int data_w,
                                                  input logic relu);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] y;
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (x > hi)
         y = hi;
      else if (x < lo)
         y = lo;
      else
         y = x;
      if (relu && (y < 64'sd0))
         y = 64'sd0;
      return y;
   endfunction

endpackage

// File: rtl/elm_neuron_mac_par_bank.sv
// Weight storage for one neuron: written one word at a time by index,
// read one LANES-wide row per cycle combinationally.
module elm_weight_bank
   import elm_neuron_mac_par_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int NUM_WEIGHT = 128,
   parameter int LANES      = 4,
   parameter int PTR_W      = $clog2(NUM_WEIGHT),
   parameter int ROW_W      = (NUM_WEIGHT / LANES > 1) ? $clog2(NUM_WEIGHT / LANES) : 1
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [PTR_W-1:0]        wr_idx,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [ROW_W-1:0]        rd_row,
   output logic [LANES*DATA_W-1:0] rd_data
);

   // Word index = row*LANES + lane, so a flat array holds the row layout.
   logic [DATA_W-1:0] mem [NUM_WEIGHT];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_data;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_rd
      assign rd_data[l*DATA_W +: DATA_W] =
         mem[PTR_W'(rd_row) * PTR_W'(LANES) + PTR_W'(l)];
   end

endmodule

// File: rtl/elm_neuron_mac_par.sv
// ELM hidden-layer neuron with LANES parallel multipliers, local weight/bias
// storage loaded over the config bus, and a valid/ready result port.
module elm_neuron_mac_par
   import elm_neuron_mac_par_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FRAC_W     = FRAC_W_DEF,
   parameter int NUM_WEIGHT = 128,
   parameter int LANES      = 4,
   parameter int LAYER_NO   = 1,
   parameter int NEURON_NO  = 0,
   parameter int ACT_MODE   = ACT_IDENTITY
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              cfg_layer,
   input  logic [7:0]              cfg_neuron,
   input  logic                    w_valid,
   input  logic [DATA_W-1:0]       w_data,
   input  logic                    b_valid,
   input  logic [DATA_W-1:0]       b_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic                    busy,
   output logic                    cfg_err
);

   localparam int BEATS  = NUM_WEIGHT / LANES;
   localparam int ACC_W  = 2 * DATA_W + $clog2(NUM_WEIGHT) + 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam int PTR_W  = $clog2(NUM_WEIGHT);
   localparam int CNT_W  = $clog2(BEATS + 1);
   localparam int ROW_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic RELU = (ACT_MODE == ACT_RELU);

   state_t                   state, state_n;
   logic [PTR_W-1:0]         w_ptr;
   logic [CNT_W-1:0]         beat_cnt;
   logic [DATA_W-1:0]        bias_reg;
   logic signed [ACC_W-1:0]  acc, prod_sum, acc_sh;
   logic signed [63:0]       acc_wide;
   logic signed [PROD_W-1:0] prod_q [LANES];
   logic                     prod_vld;
   logic [LANES*DATA_W-1:0]  w_row;
   logic                     match, accept, w_wr, b_wr, last_beat;

   assign match     = (cfg_layer == 8'(LAYER_NO)) && (cfg_neuron == 8'(NEURON_NO));
   assign w_wr      = w_valid && match && (state == S_IDLE);
   assign b_wr      = b_valid && match && (state == S_IDLE);
   assign accept    = in_valid && in_ready;
   assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
   assign busy      = (state != S_IDLE);
   assign acc_sh    = acc >>> FRAC_W;
   assign acc_wide  = 64'(acc_sh);

   elm_weight_bank #(
      .DATA_W    (DATA_W),
      .NUM_WEIGHT(NUM_WEIGHT),
      .LANES     (LANES),
      .PTR_W     (PTR_W),
      .ROW_W     (ROW_W)
   ) u_bank (
      .clk    (clk),
      .wr_en  (w_wr),
      .wr_idx (w_ptr),
      .wr_data(w_data),
      .rd_row (ROW_W'(beat_cnt)),
      .rd_data(w_row)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_n = last_beat ? S_DRAIN : S_ACCUM;
         end
         S_ACCUM: begin
            in_ready = (beat_cnt < CNT_W'(BEATS));
            if (in_valid && in_ready && last_beat)
               state_n = S_DRAIN;
         end
         S_DRAIN: state_n = S_BIAS;
         S_BIAS:  state_n = S_ACT;
         S_ACT:   state_n = S_HOLD;
         S_HOLD: begin
            if (out_valid && out_ready)
               state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      if (rst)
         in_ready = 1'b0;
   end

   // Stage 1: one registered full-precision product per lane.
   for (genvar l = 0; l < LANES; l++) begin : g_mul
      always_ff @(posedge clk) begin
         if (accept)
            prod_q[l] <= $signed(in_data[l*DATA_W +: DATA_W]) *
                         $signed(w_row[l*DATA_W +: DATA_W]);
      end
   end

   always_comb begin
      prod_sum = '0;
      for (int l = 0; l < LANES; l++)
         prod_sum = prod_sum + ACC_W'(prod_q[l]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr     <= '0;
         bias_reg  <= '0;
         acc       <= '0;
         beat_cnt  <= '0;
         prod_vld  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err  <= match && (w_valid || b_valid) && (state != S_IDLE);
         prod_vld <= accept;
         if (w_wr)
            w_ptr <= (w_ptr == PTR_W'(NUM_WEIGHT - 1)) ? '0 : w_ptr + 1'b1;
         if (b_wr)
            bias_reg <= b_data;
         if (accept)
            beat_cnt <= beat_cnt + 1'b1;
         case (state)
            S_BIAS: acc <= acc + (ACC_W'($signed(bias_reg)) <<< FRAC_W);
            S_ACT: begin
               out_valid <= 1'b1;
               out_data  <= DATA_W'(sat_act(acc_wide, DATA_W, RELU));
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  beat_cnt  <= '0;
               end
            end
            // Stage 2 runs in IDLE/ACCUM/DRAIN; DRAIN absorbs the last row.
            default: begin
               if (prod_vld)
                  acc <= acc + prod_sum;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elm_neuron_mac_par.sv
// Directed bench for elm_neuron_mac_par: an identity neuron (0) and a ReLU
// neuron (1) share the config bus; expected results are hand-computed.
module tb_elm_neuron_mac_par;

   logic        clk;
   logic        rst;
   logic [7:0]  cfg_layer, cfg_neuron;
   logic        w_valid, b_valid;
   logic [15:0] w_data, b_data;
   logic [63:0] in_data;
   logic        in_valid, in_ready, out_valid, out_ready, busy, cfg_err;
   logic [15:0] out_data;
   logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_busy, r_cfg_err;
   logic [15:0] r_out_data;

   int total = 0;
   int bad   = 0;

   elm_neuron_mac_par #(
      .DATA_W(16), .FRAC_W(8), .NUM_WEIGHT(8), .LANES(4),
      .LAYER_NO(1), .NEURON_NO(0), .ACT_MODE(0)
   ) u_dut (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
      .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .cfg_err(cfg_err)
   );

   elm_neuron_mac_par #(
      .DATA_W(16), .FRAC_W(8), .NUM_WEIGHT(8), .LANES(4),
      .LAYER_NO(1), .NEURON_NO(1), .ACT_MODE(1)
   ) u_relu (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
      .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(in_data),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
      .busy(r_busy), .cfg_err(r_cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_w(input logic [7:0] neuron, input logic [15:0] v, input int n);
      cfg_neuron = neuron;
      w_data     = v;
      w_valid    = 1'b1;
      repeat (n) tick();
      w_valid    = 1'b0;
   endtask

   task automatic wr_b(input logic [7:0] neuron, input logic [15:0] v);
      cfg_neuron = neuron;
      b_data     = v;
      b_valid    = 1'b1;
      tick();
      b_valid    = 1'b0;
   endtask

   task automatic send(input bit relu, input logic [15:0] v, input int n);
      in_data = {4{v}};
      if (relu) r_in_valid = 1'b1;
      else      in_valid   = 1'b1;
      repeat (n) tick();
      in_valid   = 1'b0;
      r_in_valid = 1'b0;
   endtask

   task automatic get_result(input bit relu, input logic [15:0] exp, input string tag);
      int n = 0;
      while (!(relu ? r_out_valid : out_valid) && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(relu ? r_out_valid : out_valid), 32'd1);
      check(tag, 32'(relu ? r_out_data : out_data), 32'(exp));
      if (relu) r_out_ready = 1'b1;
      else      out_ready   = 1'b1;
      tick();
      out_ready   = 1'b0;
      r_out_ready = 1'b0;
      check({tag, "_clr"}, 32'(relu ? r_out_valid : out_valid), 32'd0);
   endtask

   initial begin
      logic saw;
      rst = 1'b1;
      cfg_layer = 8'd1; cfg_neuron = 8'd0;
      w_valid = 1'b0; w_data = '0; b_valid = 1'b0; b_data = '0;
      in_valid = 1'b0; r_in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; r_out_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_r_out_valid", 32'(r_out_valid), 32'd0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Scenario 1: 8 x (0.5*1.0) + 0.25 = 4.25 -> 0x0440, exact latency
      wr_w(8'd0, 16'h0100, 8);
      wr_b(8'd0, 16'h0040);
      send(1'b0, 16'h0080, 2);
      tick(); tick();
      check("lat_t3", 32'(out_valid), 32'd0);
      tick();
      check("lat_t4", 32'(out_valid), 32'd1);
      check("s1_data", 32'(out_data), 32'h0440);

      // Back-pressure: result held, no new input accepted
      for (int i = 0; i < 6; i++) begin
         tick();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'h0440);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      check("hold_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_hs_valid", 32'(out_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      check("post_hs_busy", 32'(busy), 32'd0);

      // Unmatched writes ignored; matched write in ACCUM dropped with cfg_err
      wr_w(8'd5, 16'h7F00, 8);
      wr_b(8'd5, 16'h7FFF);
      send(1'b0, 16'h0080, 1);
      check("accum_busy", 32'(busy), 32'd1);
      cfg_neuron = 8'd0;
      w_data     = 16'h7F00;
      w_valid    = 1'b1;
      tick();
      w_valid    = 1'b0;
      check("cfg_err_pulse", 32'(cfg_err), 32'd1);
      tick();
      check("cfg_err_clear", 32'(cfg_err), 32'd0);
      send(1'b0, 16'h0080, 1);
      get_result(1'b0, 16'h0440, "unchanged");

      // Saturation, with out_ready held high ahead of out_valid
      wr_w(8'd0, 16'h7F00, 8);
      wr_b(8'd0, 16'h0000);
      out_ready = 1'b1;
      send(1'b0, 16'h7F00, 2);
      get_result(1'b0, 16'h7FFF, "sat_hi");
      out_ready = 1'b1;
      send(1'b0, 16'h8100, 2);
      get_result(1'b0, 16'h8000, "sat_lo");

      // ReLU neuron: -8.0 -> 0, +8.0 -> 0x0800
      wr_w(8'd1, 16'hFF00, 8);
      wr_b(8'd1, 16'h0000);
      send(1'b1, 16'h0100, 2);
      get_result(1'b1, 16'h0000, "relu_neg");
      wr_w(8'd1, 16'h0100, 8);
      send(1'b1, 16'h0100, 2);
      get_result(1'b1, 16'h0800, "relu_pos");

      // Reset mid-vector: no result; weights retained, bias cleared
      wr_w(8'd0, 16'h0100, 8);
      wr_b(8'd0, 16'h0040);
      send(1'b0, 16'h0080, 1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      check("rst_mid_in_ready", 32'(in_ready), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         saw = saw | out_valid;
      end
      check("rst_no_valid", 32'(saw), 32'd0);
      send(1'b0, 16'h0080, 2);
      get_result(1'b0, 16'h0400, "retain_nobias");
      wr_b(8'd0, 16'h0040);
      send(1'b0, 16'h0080, 2);
      get_result(1'b0, 16'h0440, "retain_bias");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/elm_neuron_mac_par.md
Name: elm_neuron_mac_par

Overview:
Parametrised hidden-layer neuron for the ELM datapath. It replaces the single-MAC neuron with LANES parallel multipliers. It stores its own weights and bias, loaded over the shared config bus with a layer/neuron match. It accumulates NUM_WEIGHT products in full precision, adds the bias, and emits one saturated, activated DATA_W result per input vector over a valid/ready handshake. It sits between the input broadcast stage and the layer output collector.

Parameters:
DATA_W, 16, width of input/weight/bias/output words (signed fixed point).
FRAC_W, 8, fractional bits of all DATA_W words.
NUM_WEIGHT, 128, weights per neuron; must be a multiple of LANES.
LANES, 4, parallel multipliers and input words per beat.
LAYER_NO, 1, layer id matched against cfg_layer.
NEURON_NO, 0, neuron id matched against cfg_neuron.
ACT_MODE, 0, 0 = identity, 1 = ReLU.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_layer  in  8  target layer for weight/bias writes
cfg_neuron  in  8  target neuron for weight/bias writes
w_valid  in  1  weight write strobe
w_data  in  DATA_W  weight value
b_valid  in  1  bias write strobe
b_data  in  DATA_W  bias value
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when both high
in_data  in  LANES*DATA_W  LANES input words; lane 0 in the LSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  activated result
busy  out  1  a vector is in flight (not IDLE)
cfg_err  out  1  one-cycle pulse when a matched write is dropped

Behaviour:
- Derived values:
  - BEATS = NUM_WEIGHT/LANES.
  - ACC_W = 2*DATA_W + clog2(NUM_WEIGHT) + 1.
- Match condition: cfg_layer==LAYER_NO and cfg_neuron==NEURON_NO.
- Weight write (w_valid and match, state IDLE):
  - writes w_data at w_ptr, stored in row w_ptr/LANES, lane w_ptr%LANES.
  - w_ptr increments and wraps from NUM_WEIGHT-1 to 0.
- Bias write (b_valid and match, state IDLE): bias_reg <= b_data.
- Matched w_valid/b_valid outside IDLE are dropped: no write, cfg_err pulses for 1 cycle.
- Reset values:
  - w_ptr=0, bias_reg=0, acc=0, beat_cnt=0.
  - state=IDLE, in_ready=0 during rst, out_valid=0, out_data=0, cfg_err=0.
  - Weight array is not cleared.
- FSM states: IDLE, ACCUM, DRAIN, BIAS, ACT, HOLD.
  - IDLE: in_ready=1; first accepted beat -> ACCUM.
  - ACCUM: in_ready=1 while beat_cnt<BEATS; accepting beat BEATS-1 -> DRAIN.
  - Gaps (in_valid=0) allowed anywhere; state holds.
  - DRAIN: 1 cycle, last product row enters acc.
  - BIAS: acc <= acc + sign-extended(bias_reg) << FRAC_W.
  - ACT: out_data <= act(sat(acc >>> FRAC_W)), out_valid <= 1 -> HOLD.
  - HOLD: out_valid and out_data stable until out_ready; then out_valid=0, acc=0, beat_cnt=0 -> IDLE.
  - in_ready=0 in DRAIN/BIAS/ACT/HOLD.
- Pipeline:
  - beat k: products p[l] = signed(in_data lane l) * signed(w[row k][l]), registered (stage 1).
  - next cycle: acc += sum of p[l] over all lanes (stage 2).
  - Last beat accepted at cycle t -> out_valid high at t+4.
  - BEATS consecutive beats: out_valid at first-beat cycle + BEATS + 3.
- Arithmetic:
  - products and acc are full precision, no internal overflow.
  - The >>> is arithmetic (floor).
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ReLU maps negative to 0 after saturation.
- out_ready may be high before out_valid; the result is consumed the first cycle both are high.
- rst mid-operation: abort to IDLE next cycle, out_valid=0, partial acc discarded.

Decomposition:
- Shared package: DATA_W/FRAC_W defaults, ACT_MODE encodings, FSM state enum, the sat/ReLU function.
- Sub-module elm_weight_bank: LANES-wide row memory, write-by-index, combinational row read (registered output optional if stage 1 shifts).

Test Plan:
1. NUM_WEIGHT=8, LANES=4; weights all 0x0100, bias 0x0040; two beats of inputs all 0x0080 -> out_data=0x0440 at t+4, out_valid held until out_ready.
2. Weights 0x7F00, inputs 0x7F00, bias 0 -> out_data=0x7FFF. Same with inputs 0x8100 -> 0x8000 (ACT_MODE=0).
3. ACT_MODE=1; weights 0xFF00, inputs 0x0100, bias 0 -> out_data=0x0000. Repeat with weights 0x0100 -> 0x0800.
4. Writes with cfg_neuron≠NEURON_NO -> result unchanged. Matched w_valid during ACCUM -> cfg_err pulse, weights unchanged.
5. out_ready low 6 cycles after out_valid -> out_valid/out_data stable, in_ready=0. Release -> next vector accepted the cycle after handshake.
6. Assert rst after 1 of 2 beats -> out_valid never rises. A fresh vector gives the scenario-1 result using the retained weights; bias reads 0 unless reloaded.
